// File: rtl/w80386dx_bus_pkg.sv
// Shared types for the 80386 external bus cycle controller.
// Bus phases, request bundle and wait counter sizing.
package w80386dx_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        T1,
        T2
    } bus_state_t;

    typedef struct packed {
        logic        write;
        logic        mio;
        logic [31:0] address;
        logic [3:0]  byte_enable;
        logic [31:0] wdata;
    } bus_request_t;

    localparam logic [3:0] BE_NONE = 4'hF;

    // A limit of zero disables the timeout but still needs a 1-bit counter.
    function automatic int unsigned wait_count_width(input int unsigned limit);
        if (limit == 0) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/bus_cycle_controller_watchdog.sv
// Wait-state watchdog: counts T2 cycles with READY# high.
// Saturates at WAIT_LIMIT and flags the edge that reaches it.
module bus_wait_watchdog
    import w80386dx_bus_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = wait_count_width(WAIT_LIMIT);
    localparam logic [CW-1:0] SAT = CW'(WAIT_LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != SAT)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Combinational so the abort lands on the very edge the limit is hit.
    assign expired = (WAIT_LIMIT != 0) && count_en && (count_d == SAT);

endmodule

// File: rtl/bus_cycle_controller.sv
// 80386 non-pipelined bus cycle engine (T1, T2 + wait states).
// One physical access at a time, one response per access.
module bus_cycle_controller
    import w80386dx_bus_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_mio,
    input  logic [31:0] req_address,
    input  logic [3:0]  req_byte_enable,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_error,
    output logic [31:0] rsp_rdata,
    output logic [29:0] bus_address,
    output logic [3:0]  bus_byte_enable_n,
    output logic        bus_ads_n,
    output logic        bus_w_r_n,
    output logic        bus_m_io_n,
    output logic [31:0] bus_data_out,
    output logic        bus_data_oe,
    input  logic        bus_ready_n,
    input  logic [31:0] bus_data_in
);

    bus_state_t   state_q;
    bus_request_t req;
    logic         accept;
    logic         wd_clear;
    logic         wd_count;
    logic         wd_expired;
    logic         unused_addr_lsb;

    assign req = '{
        write:       req_write,
        mio:         req_mio,
        address:     req_address,
        byte_enable: req_byte_enable,
        wdata:       req_wdata
    };

    // Dword-aligned bus: the two low address bits never reach A[31:2].
    assign unused_addr_lsb = ^req.address[1:0];

    assign accept   = req_valid && req_ready;
    assign wd_clear = (state_q == T1);
    assign wd_count = (state_q == T2) && bus_ready_n;

    bus_wait_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .count_en (wd_count),
        .expired  (wd_expired)
    );

    // Bus phase FSM; the bus pins are loaded at accept so ADS# is low in T1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            req_ready         <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_error         <= 1'b0;
            rsp_rdata         <= '0;
            bus_address       <= '0;
            bus_byte_enable_n <= BE_NONE;
            bus_ads_n         <= 1'b1;
            bus_w_r_n         <= 1'b0;
            bus_m_io_n        <= 1'b1;
            bus_data_out      <= '0;
            bus_data_oe       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            unique case (state_q)
                IDLE: begin
                    req_ready         <= 1'b1;
                    bus_byte_enable_n <= BE_NONE;
                    bus_data_oe       <= 1'b0;
                    if (accept) begin
                        if (req.byte_enable == 4'h0) begin
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                        end else begin
                            state_q           <= T1;
                            req_ready         <= 1'b0;
                            bus_ads_n         <= 1'b0;
                            bus_address       <= req.address[31:2];
                            bus_byte_enable_n <= ~req.byte_enable;
                            bus_w_r_n         <= req.write;
                            bus_m_io_n        <= req.mio;
                            bus_data_out      <= req.wdata;
                            bus_data_oe       <= req.write;
                        end
                    end
                end
                T1: begin
                    bus_ads_n <= 1'b1;
                    state_q   <= T2;
                end
                T2: begin
                    if (!bus_ready_n) begin
                        state_q           <= IDLE;
                        req_ready         <= 1'b1;
                        rsp_valid         <= 1'b1;
                        rsp_rdata         <= bus_w_r_n ? 32'h0 : bus_data_in;
                        bus_byte_enable_n <= BE_NONE;
                        bus_data_oe       <= 1'b0;
                    end else if (wd_expired) begin
                        state_q           <= IDLE;
                        req_ready         <= 1'b1;
                        rsp_valid         <= 1'b1;
                        rsp_error         <= 1'b1;
                        bus_byte_enable_n <= BE_NONE;
                        bus_data_oe       <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bus_ads_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
